// File: rtl/fpmul_tb_pkg.sv
// fpmul_tb_pkg: shared widths, float classification helpers and checker FSM states
package fpmul_tb_pkg;
    localparam int FP_W     = 32;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = FP_W - 1 - FP_EXP_W;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (&x[FP_W-2:FP_MAN_W]) && (|x[FP_MAN_W-1:0]);
    endfunction

    function automatic logic is_zero(input logic [FP_W-1:0] x);
        return ~|x[FP_W-2:0];
    endfunction
endpackage

// File: rtl/fpmul_result_checker_if.sv
// fpmul_result_checker_if: expected-value, result and status bundle of the checker
interface fpmul_result_checker_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              i_exp_valid;
    logic [DATA_W-1:0] i_exp_data;
    logic              o_exp_ready;
    logic              i_vin;
    logic [DATA_W-1:0] i_din;
    logic              i_end_sim;
    logic              o_cmp_valid;
    logic              o_err;
    logic              o_err_sticky;
    logic [CNT_W-1:0]  o_match_cnt;
    logic [CNT_W-1:0]  o_err_cnt;
    logic              o_done;
    logic              o_pass;

    modport slave (
        input  i_exp_valid, i_exp_data, i_vin, i_din, i_end_sim,
        output o_exp_ready, o_cmp_valid, o_err, o_err_sticky, o_match_cnt, o_err_cnt, o_done, o_pass
    );

    modport master (
        output i_exp_valid, i_exp_data, i_vin, i_din, i_end_sim,
        input  o_exp_ready, o_cmp_valid, o_err, o_err_sticky, o_match_cnt, o_err_cnt, o_done, o_pass
    );
endinterface

// File: rtl/fpmul_exp_fifo.sv
// fpmul_exp_fifo: synchronous FIFO holding expected products; caller gates push/pop
module fpmul_exp_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_din,
    output logic [DATA_W-1:0]        o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;

    // read/write pointers carry one extra wrap bit to separate full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    // storage needs no reset: pointers define what is valid
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_count = r_wptr - r_rptr;
    assign o_full  = o_count == (AW+1)'(DEPTH);
    assign o_empty = r_wptr == r_rptr;
    assign o_dout  = r_mem[r_rptr[AW-1:0]];
endmodule

// File: rtl/fpmul_result_checker.sv
// fpmul_result_checker: compares multiplier results against queued expectations and reports pass/fail
module fpmul_result_checker
    import fpmul_tb_pkg::*;
#(
    parameter int DATA_W  = FP_W,
    parameter int DEPTH   = 8,
    parameter int ULP_TOL = 0,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    fpmul_result_checker_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-2:0] TOL = (DATA_W-1)'(ULP_TOL);

    state_t            r_state;
    state_t            w_next;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    logic [AW:0]       w_missing;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_vin;
    logic              w_pop;
    logic              w_match;
    logic              w_bad;
    logic              w_timeout;
    logic [DATA_W-2:0] w_diff;
    logic [CNT_W:0]    w_err_inc;
    logic [TW-1:0]     r_timer;
    logic              r_cmp_valid;
    logic              r_err;
    logic              r_sticky;
    logic [CNT_W-1:0]  r_match_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W:0] b);
        logic [CNT_W+1:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    fpmul_exp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (bus.i_exp_data),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // a full FIFO refuses pushes even when a pop frees a slot in the same cycle
    assign w_push    = bus.i_exp_valid && !w_full && r_state != ST_DONE;
    assign w_vin     = bus.i_vin && r_state != ST_DONE;
    assign w_pop     = w_vin && !w_empty;
    assign w_diff    = (bus.i_din[DATA_W-2:0] >= w_head[DATA_W-2:0]) ?
                       bus.i_din[DATA_W-2:0] - w_head[DATA_W-2:0] :
                       w_head[DATA_W-2:0] - bus.i_din[DATA_W-2:0];
    assign w_match   = (is_nan(bus.i_din) && is_nan(w_head)) ||
                       (is_zero(bus.i_din) && is_zero(w_head)) ||
                       (bus.i_din[DATA_W-1] == w_head[DATA_W-1] && w_diff <= TOL);
    assign w_bad     = w_vin && (w_empty || !w_match);
    assign w_timeout = r_state == ST_DRAIN && !w_empty && r_timer == '0;
    assign w_missing = w_count - {{AW{1'b0}}, w_pop};
    assign w_err_inc = (CNT_W+1)'(w_bad) + (w_timeout ? (CNT_W+1)'(w_missing) : '0);

    // comparison result and counters register together, one cycle after VIN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_cmp_valid <= w_vin;
            r_err       <= w_bad;
            if (w_bad || w_timeout) r_sticky <= 1'b1;
            r_match_cnt <= sat_add(r_match_cnt, (CNT_W+1)'(w_pop && w_match));
            r_err_cnt   <= sat_add(r_err_cnt, w_err_inc);
        end
    end

    // drain timer reloads while running and counts down while draining
    always_ff @(posedge clk) begin
        if (rst) r_timer <= '0;
        else if (r_state == ST_RUN) r_timer <= TW'(TIMEOUT);
        else if (r_state == ST_DRAIN && r_timer != '0) r_timer <= r_timer - 1'b1;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else r_state <= w_next;
    end

    // next state: drain ends when the FIFO empties or the timer expires
    always_comb begin
        w_next = r_state;
        if (r_state == ST_RUN) w_next = bus.i_end_sim ? ST_DRAIN : ST_RUN;
        else if (r_state == ST_DRAIN) w_next = (w_empty || r_timer == '0) ? ST_DONE : ST_DRAIN;
    end

    // outputs
    always_comb begin
        bus.o_done       = r_state == ST_DONE;
        bus.o_pass       = r_state == ST_DONE && r_err_cnt == '0;
        bus.o_exp_ready  = !w_full && r_state != ST_DONE;
        bus.o_cmp_valid  = r_cmp_valid;
        bus.o_err        = r_err;
        bus.o_err_sticky = r_sticky;
        bus.o_match_cnt  = r_match_cnt;
        bus.o_err_cnt    = r_err_cnt;
    end
endmodule

// File: doc/fpmul_result_checker.md
Name: fpmul_result_checker

Overview:
- Self-checking consumer placed directly downstream of the FP multiplier.
- Receives expected products from the stimulus side into an internal FIFO, which absorbs the multiplier's pipeline latency.
- Pops one expected value per valid multiplier result and compares it within a ULP tolerance (NaN-aware).
- Counts matches/errors; an end-of-simulation drain FSM raises DONE/PASS.

Parameters:
DATA_W, 32, operand/result width (IEEE-754 single; exponent 8 bits, mantissa DATA_W-9 bits)
DEPTH, 8, expected-value FIFO depth; power of 2, >=2
ULP_TOL, 0, maximum allowed |DIN-EXP_DATA| in raw-bit units when signs are equal
CNT_W, 16, width of MATCH_CNT / ERR_CNT
TIMEOUT, 64, drain cycles allowed after END_SIM before declaring missing results

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  synchronous reset, active-high
EXP_VALID  in  1  expected value offered
EXP_DATA  in  DATA_W  expected product
EXP_READY  out  1  FIFO not full; a push occurs when EXP_VALID & EXP_READY
VIN  in  1  multiplier result valid
DIN  in  DATA_W  multiplier result
END_SIM  in  1  stimulus exhausted (level; sampled each cycle)
CMP_VALID  out  1  one-cycle pulse: a comparison completed
ERR  out  1  one-cycle pulse with CMP_VALID on mismatch or orphan result
ERR_STICKY  out  1  set on any error; cleared only by RST
MATCH_CNT  out  CNT_W  saturating count of matches
ERR_CNT  out  CNT_W  saturating count of errors (mismatch + orphan + missing)
DONE  out  1  drain finished; held until RST
PASS  out  1  valid when DONE; 1 iff ERR_CNT==0

Behaviour:
- Reset (RST=1 at a CLK edge): FIFO empty, all counters 0, all outputs 0 except EXP_READY=1, FSM->RUN. Reset mid-operation discards all queued expectations and any in-flight comparison.
- FIFO: pointers log2(DEPTH)+1 bits, wrap at DEPTH. EXP_READY = !full, combinational from registered occupancy. No push while full, even if a pop occurs in the same cycle. Push and pop in the same cycle with 0<occupancy<DEPTH: occupancy unchanged.
- Compare: VIN=1 with FIFO non-empty pops the head. Stage-1 registers DIN and the head; the result appears the next cycle (CMP_VALID latency = 1 cycle after VIN).
- Orphan: VIN=1 with FIFO empty means no pop, and 1 cycle later CMP_VALID=1, ERR=1. A same-cycle push is still stored and is not used for this result.
- Match rule:
  - Both NaN (exp all ones, mantissa!=0): match.
  - Both zero of either sign: match.
  - Signs differ: mismatch.
  - Otherwise: match iff |DIN[DATA_W-2:0] - EXP[DATA_W-2:0]| <= ULP_TOL (unsigned, DATA_W-1 bits).
- Counters saturate at all-ones; no wrap.
- FSM:
  - RUN: normal operation; END_SIM=1 -> DRAIN, load timer with TIMEOUT.
  - DRAIN: comparisons continue; pushes still accepted. When FIFO empty and no comparison is in flight -> DONE. When the timer reaches 0 -> DONE, and ERR_CNT += occupancy (saturating); ERR_STICKY set; ERR not pulsed.
  - DONE: DONE=1, PASS=(ERR_CNT==0). Further VIN is ignored; EXP_READY=0. Exit only via RST.
- END_SIM deassertion during DRAIN has no effect.

Decomposition:
- Package fpmul_tb_pkg:
  - DATA_W/exponent/mantissa widths
  - NaN/zero classification function
  - FSM state enum {RUN, DRAIN, DONE}
- One sub-module: fpmul_exp_fifo (parameterised synchronous FIFO: push/pop/full/empty/count). The compare pipeline, counters and FSM stay in the top.

Test Plan:
- Push 3 expectations 0x40400000, 0x40800000, 0x3F800000; then VIN with the same values at 3-cycle latency -> 3 CMP_VALID pulses, ERR never 1, MATCH_CNT=3; END_SIM -> DONE=1, PASS=1.
- ULP_TOL=1: expect 0x40400000, DIN 0x40400001 -> match. DIN 0x40400002 -> ERR pulse, ERR_CNT=1, ERR_STICKY=1.
- Special values: expect 0x7FC00000 with DIN 0x7F800001 -> match; expect 0x00000000 with DIN 0x80000000 -> match; expect 0x3F800000 with DIN 0xBF800000 -> mismatch.
- Fill 8 expectations without VIN -> EXP_READY=0 and the 9th push is refused. Then assert EXP_VALID and VIN in the same cycle -> a pop occurs, no push, and EXP_READY=1 on the next cycle.
- VIN with FIFO empty -> CMP_VALID=1, ERR=1, ERR_CNT=1 one cycle later. Then push 2 expectations, END_SIM, never VIN -> after 64 cycles DONE=1, ERR_CNT=3, PASS=0.
- Assert RST mid-stream with 4 queued expectations -> next cycle counters 0, EXP_READY=1, FIFO empty. A subsequent VIN is treated as an orphan.
